rv32i_issue_ctrl: RTL and testbench

Issue controller for the RV32I decode stage. It sits between fetch and the decoder and generates the decoder's clock-enable, stall and flush. It sequences the decode stage through four cases: load-use hazards, serialization of SYSTEM/FENCE instructions, in-flight back-pressure, and trap/redirect flushes. It also tracks how many issued instructions have not yet retired.

---
 rtl/rv32i_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rv32i_issue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_issue_ctrl.sv
// Decode-stage issue controller for an in-order RV32I pipeline: generates decoder
// clock-enable, stall and flush, and counts issued-but-not-retired instructions.
//
// Handshake: fetch presents an instruction with i_fetch_ce. It is accepted (issued)
// in a cycle only when o_dec_ce is high and both o_dec_stall and o_dec_flush are low.
// Otherwise fetch must hold the same instruction on i_inst for the next cycle.
module rv32i_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 2,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_fetch_ce,
  input  logic [31:0]   i_inst,
  input  logic          i_ex_ce,
  input  logic          i_ex_load,
  input  logic [4:0]    i_ex_rd_addr,
  input  logic          i_retire,
  input  logic          i_trap,
  input  logic          i_mem_stall,
  output logic          o_dec_ce,
  output logic          o_dec_stall,
  output logic          o_fetch_stall,
  output logic          o_dec_flush,
  output logic [CW-1:0] o_inflight,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_LOADUSE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [1:0]    LD_INIT = (LOAD_STALL > 0) ? 2'(LOAD_STALL - 1) : 2'd0;
  localparam logic [2:0]    FL_INIT = 3'(FLUSH_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_ld_cnt;
  logic [1:0]    w_ld_cnt_nxt;
  logic [2:0]    r_fl_cnt;
  logic [2:0]    w_fl_cnt_nxt;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] w_inflight_nxt;

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_op;
  logic       w_serial;
  logic       w_hazard;
  logic       w_full;
  logic       w_busy;
  logic       w_run_block;
  logic       w_stall;
  logic       w_ce;
  logic       w_flush;
  logic       w_issue;
  logic       w_retire;
  logic       w_unused;

  // Only the register and opcode fields matter here; the rest of the word is ignored.
  assign w_unused = ^{i_inst[31:25], i_inst[14:7]};

  assign w_rs1    = i_inst[19:15];
  assign w_rs2    = i_inst[24:20];
  assign w_op     = i_inst[6:0];
  assign w_serial = (w_op == 7'b1110011) || (w_op == 7'b0001111);

  // Conservative: any rs field match counts, even if the format has no such source.
  assign w_hazard = i_ex_ce && i_ex_load && (i_ex_rd_addr != 5'd0) &&
                    ((i_ex_rd_addr == w_rs1) || (i_ex_rd_addr == w_rs2));

  assign w_full      = (r_inflight == MAX_CNT);
  assign w_busy      = (r_inflight != '0);
  assign w_run_block = i_fetch_ce && (w_hazard || w_full || (w_serial && w_busy));
  assign w_retire    = i_retire && w_busy;

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_ld_cnt   <= 2'd0;
      r_fl_cnt   <= 3'd0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_cnt   <= w_ld_cnt_nxt;
      r_fl_cnt   <= w_fl_cnt_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_cnt_nxt = r_ld_cnt;
    w_fl_cnt_nxt = r_fl_cnt;
    if (i_trap) begin
      w_state_nxt  = ST_FLUSH;
      w_fl_cnt_nxt = FL_INIT;
    end else if (!i_mem_stall) begin
      unique case (r_state)
        ST_RUN: begin
          if (i_fetch_ce && w_hazard) begin
            if (LOAD_STALL > 0) begin
              w_state_nxt  = ST_LOADUSE;
              w_ld_cnt_nxt = LD_INIT;
            end
          end else if (i_fetch_ce && w_serial && w_busy) begin
            w_state_nxt = ST_DRAIN;
          end else if (w_issue && w_serial) begin
            // Younger instructions wait until the serial one retires.
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!w_busy) w_state_nxt = ST_RUN;
        end
        ST_LOADUSE: begin
          if (r_ld_cnt == 2'd0) w_state_nxt = ST_RUN;
          else                  w_ld_cnt_nxt = r_ld_cnt - 2'd1;
        end
        ST_FLUSH: begin
          if (r_fl_cnt == 3'd0) w_state_nxt = ST_RUN;
          else                  w_fl_cnt_nxt = r_fl_cnt - 3'd1;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Inflight count: a trap squashes everything younger, so retire is ignored that cycle.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (i_trap) w_inflight_nxt = '0;
    else        w_inflight_nxt = r_inflight + CW'(w_issue) - CW'(w_retire);
  end

  // Output logic; reset forces every combinational output low.
  always_comb begin
    w_stall = 1'b0;
    w_ce    = 1'b0;
    w_flush = 1'b0;
    if (i_rst_n) begin
      w_stall = i_mem_stall || ((r_state == ST_RUN) && w_run_block) ||
                (r_state == ST_DRAIN) || (r_state == ST_LOADUSE);
      w_ce    = i_fetch_ce && !i_trap && (r_state != ST_FLUSH);
      w_flush = i_trap || (r_state == ST_FLUSH);
    end
  end

  assign w_issue       = w_ce && !w_stall && !w_flush;
  assign o_dec_ce      = w_ce;
  assign o_dec_stall   = w_stall;
  assign o_fetch_stall = w_stall;
  assign o_dec_flush   = w_flush;
  assign o_inflight    = r_inflight;
  assign o_state       = r_state;

endmodule

// File: tb/tb_rv32i_issue_ctrl.sv
// Directed bench for rv32i_issue_ctrl with default parameters
// (MAX_INFLIGHT=4, LOAD_STALL=1, FLUSH_CYCLES=2).
module tb_rv32i_issue_ctrl;

  localparam logic [31:0] ADD_A  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] ADD_H  = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] ADD_Z  = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] ECALL  = 32'h00000073;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_fetch_ce;
  logic [31:0] i_inst;
  logic        i_ex_ce;
  logic        i_ex_load;
  logic [4:0]  i_ex_rd_addr;
  logic        i_retire;
  logic        i_trap;
  logic        i_mem_stall;
  logic        o_dec_ce;
  logic        o_dec_stall;
  logic        o_fetch_stall;
  logic        o_dec_flush;
  logic [2:0]  o_inflight;
  logic [1:0]  o_state;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  rv32i_issue_ctrl dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_fetch_ce    (i_fetch_ce),
    .i_inst        (i_inst),
    .i_ex_ce       (i_ex_ce),
    .i_ex_load     (i_ex_load),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .i_retire      (i_retire),
    .i_trap        (i_trap),
    .i_mem_stall   (i_mem_stall),
    .o_dec_ce      (o_dec_ce),
    .o_dec_stall   (o_dec_stall),
    .o_fetch_stall (o_fetch_stall),
    .o_dec_flush   (o_dec_flush),
    .o_inflight    (o_inflight),
    .o_state       (o_state)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: inputs change 1 ns after the rising edge.
  task automatic drive(input logic fetch, input logic [31:0] inst, input logic ex_ce,
                       input logic ex_load, input logic [4:0] rd, input logic retire,
                       input logic trap, input logic mem_stall);
    i_fetch_ce   = fetch;
    i_inst       = inst;
    i_ex_ce      = ex_ce;
    i_ex_load    = ex_load;
    i_ex_rd_addr = rd;
    i_retire     = retire;
    i_trap       = trap;
    i_mem_stall  = mem_stall;
  endtask

  // Check one cycle at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input int e_ce, input int e_stall, input int e_flush,
                      input int e_state, input int e_inf);
    @(negedge i_clk);
    chk({tag, ".ce"},     {31'd0, o_dec_ce},      e_ce);
    chk({tag, ".stall"},  {31'd0, o_dec_stall},   e_stall);
    chk({tag, ".fstall"}, {31'd0, o_fetch_stall}, e_stall);
    chk({tag, ".flush"},  {31'd0, o_dec_flush},   e_flush);
    chk({tag, ".state"},  {30'd0, o_state},       e_state);
    chk({tag, ".inf"},    {29'd0, o_inflight},    e_inf);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    i_rst_n = 1'b0;
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    step("rst", 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;

    // Back-to-back ADDs retiring two cycles after issue
    for (int i = 0; i < 7; i++) exp_q.push_back((i == 0) ? 32'd0 : (i == 1) ? 32'd1 : 32'd2);
    for (int i = 0; i < 7; i++) begin
      logic [31:0] e_inf;
      e_inf = exp_q.pop_front();
      drive(1, ADD_A, 0, 0, 0, (i >= 2), 0, 0);
      step("b2b", 1, 0, 0, 0, int'(e_inf));
    end
    drive(0, ADD_A, 0, 0, 0, 1, 0, 0);
    step("b2b_d0", 0, 0, 0, 0, 2);
    step("b2b_d1", 0, 0, 0, 0, 1);
    drive(1, ADD_A, 0, 0, 0, 0, 0, 1);
    step("memstall", 1, 1, 0, 0, 0);
    drive(0, ADD_A, 0, 0, 0, 0, 0, 0);
    step("memstall_hold", 0, 0, 0, 0, 0);

    // Load-use: LOAD x5 in EX, add x6,x5,x1 at decode
    drive(1, ADD_H, 1, 1, 5'd5, 0, 0, 0);
    step("lu_hz", 1, 1, 0, 0, 0);
    drive(1, ADD_H, 0, 0, 5'd0, 0, 0, 0);
    step("lu_wait", 1, 1, 0, 2, 0);
    step("lu_go", 1, 0, 0, 0, 0);
    drive(1, ADD_Z, 1, 1, 5'd0, 1, 0, 0);
    step("lu_x0", 1, 0, 0, 0, 1);
    drive(0, ADD_A, 0, 0, 0, 1, 0, 0);
    step("lu_ret", 0, 0, 0, 0, 1);

    // ECALL arriving with three older instructions in flight
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    step("fill0", 1, 0, 0, 0, 0);
    step("fill1", 1, 0, 0, 0, 1);
    step("fill2", 1, 0, 0, 0, 2);
    drive(1, ECALL, 0, 0, 0, 0, 0, 0);
    step("ec_arr", 1, 1, 0, 0, 3);
    drive(1, ECALL, 0, 0, 0, 1, 0, 0);
    step("ec_dr3", 1, 1, 0, 1, 3);
    step("ec_dr2", 1, 1, 0, 1, 2);
    step("ec_dr1", 1, 1, 0, 1, 1);
    drive(1, ECALL, 0, 0, 0, 0, 0, 0);
    step("ec_dr0", 1, 1, 0, 1, 0);
    step("ec_iss", 1, 0, 0, 0, 0);
    drive(1, ADD_A, 0, 0, 0, 1, 0, 0);
    step("ec_ser1", 1, 1, 0, 1, 1);
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    step("ec_ser0", 1, 1, 0, 1, 0);
    step("ec_run", 1, 0, 0, 0, 0);
    drive(0, ADD_A, 0, 0, 0, 1, 0, 0);
    step("ec_ret", 0, 0, 0, 0, 1);

    // Back-pressure at MAX_INFLIGHT
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    step("full0", 1, 0, 0, 0, 0);
    step("full1", 1, 0, 0, 0, 1);
    step("full2", 1, 0, 0, 0, 2);
    step("full3", 1, 0, 0, 0, 3);
    step("full4", 1, 1, 0, 0, 4);
    step("full4b", 1, 1, 0, 0, 4);
    drive(1, ADD_A, 0, 0, 0, 1, 0, 0);
    step("full_ret", 1, 1, 0, 0, 4);
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    step("full_one", 1, 0, 0, 0, 3);
    step("full_again", 1, 1, 0, 0, 4);

    // Trap during DRAIN with three in flight
    drive(1, ECALL, 0, 0, 0, 1, 0, 0);
    step("tr_todrain", 1, 1, 0, 0, 4);
    drive(1, ECALL, 0, 0, 0, 1, 1, 0);
    step("tr_trap", 0, 1, 1, 1, 3);
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    step("tr_fl1", 0, 0, 1, 3, 0);
    step("tr_fl2", 0, 0, 1, 3, 0);
    step("tr_run", 1, 0, 0, 0, 0);
    drive(0, ADD_A, 0, 0, 0, 1, 0, 0);
    step("tr_ret", 0, 0, 0, 0, 1);

    // Reset in the middle of FLUSH
    drive(0, ADD_A, 0, 0, 0, 0, 1, 0);
    step("rf_trap", 0, 0, 1, 0, 0);
    drive(1, ADD_A, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    step("rf_rst", 0, 0, 0, 3, 0);
    i_rst_n = 1'b1;
    drive(0, ADD_A, 0, 0, 0, 0, 0, 0);
    step("rf_after", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
